// File: rtl/muntjac_pkg.sv
// Data-cache host/cache channel types shared by the cache arbiter and its bench.
package muntjac_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_LR    = 3'd2,
    OP_SC    = 3'd3,
    OP_AMO   = 3'd4
  } mem_op_e;

  typedef enum logic [3:0] {
    EXC_NONE              = 4'd0,
    EXC_LOAD_ACCESS_FAULT = 4'd5,
    EXC_STORE_FAULT       = 4'd7,
    EXC_LOAD_PAGE_FAULT   = 4'd13,
    EXC_STORE_PAGE_FAULT  = 4'd15
  } exc_cause_e;

  typedef struct packed {
    exc_cause_e  cause;
    logic [63:0] tval;
  } exception_t;

  typedef struct packed {
    logic        req_valid;
    mem_op_e     req_op;
    logic [63:0] req_address;
    logic [1:0]  req_size;
    logic [63:0] req_value;
    logic [7:0]  req_mask;
    logic        notif_valid;
    logic        notif_reason;
  } dcache_h2d_t;

  typedef struct packed {
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_value;
    logic        ex_valid;
    exception_t  ex_exception;
    logic        notif_ready;
  } dcache_d2h_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dcache_arb_state_e;

endpackage

// File: rtl/dcache_arbiter_if.sv
// One host<->cache link: the host side drives h2d, the cache side drives d2h.
interface dcache_arbiter_if;
  import muntjac_pkg::*;

  dcache_h2d_t h2d;
  dcache_d2h_t d2h;

  modport master (output h2d, input d2h);
  modport slave  (input h2d, output d2h);
endinterface

// File: rtl/dcache_arb_rr.sv
// Combinational 2-way round-robin picker; ptr names the requester preferred this cycle.
module dcache_arb_rr (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic       gnt_idx_o,
  output logic       gnt_valid_o
);

  assign gnt_idx_o   = valid_i[ptr_i] ? ptr_i : ~ptr_i;
  assign gnt_valid_o = |valid_i;

endmodule

// File: rtl/dcache_arbiter.sv
// Two-host arbiter in front of one data-cache port; one request outstanding at a time.
// Define DCACHE_ARB_ASSERT_EN for protocol assertions and sticky error flags.
module dcache_arbiter
  import muntjac_pkg::*;
#(
  parameter int NumReq = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  dcache_h2d_t [1:0]  req_h2d_i,
  output dcache_d2h_t [1:0]  req_d2h_o,
  output dcache_h2d_t        dcache_h2d_o,
  input  dcache_d2h_t        dcache_d2h_i,
  output logic               owner_o,
  output logic               busy_o
);

  if (NumReq != 2) begin : g_bad_numreq
    $fatal(1, "dcache_arbiter supports exactly two requesters");
  end

  dcache_arb_state_e state_q, state_d;
  logic owner_q, owner_d;
  logic rr_ptr_q, rr_ptr_d;
  logic notif_owner_q, notif_owner_d;
  logic notif_lock_q, notif_lock_d;

  logic gnt_idx, gnt_valid;
  logic completion, arb_open, req_fire, notif_sel;

  dcache_arb_rr u_rr (
    .valid_i     ({req_h2d_i[1].req_valid, req_h2d_i[0].req_valid}),
    .ptr_i       (rr_ptr_q),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  // The completion cycle re-opens arbitration so requests run back-to-back.
  assign completion = dcache_d2h_i.resp_valid | dcache_d2h_i.ex_valid;
  assign arb_open   = (state_q == IDLE) | completion;
  assign req_fire   = arb_open & gnt_valid & dcache_d2h_i.req_ready;
  assign notif_sel  = notif_lock_q ? notif_owner_q : ~req_h2d_i[0].notif_valid;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    notif_owner_d = notif_sel;
    notif_lock_d  = req_h2d_i[notif_sel].notif_valid & ~dcache_d2h_i.notif_ready;
    if (req_fire) begin
      state_d  = WAIT;
      owner_d  = gnt_idx;
      rr_ptr_d = ~gnt_idx;
    end else if (state_q == WAIT && completion) begin
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous to clk_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      rr_ptr_q      <= 1'b0;
      notif_owner_q <= 1'b0;
      notif_lock_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      notif_owner_q <= notif_owner_d;
      notif_lock_q  <= notif_lock_d;
    end
  end

  always_comb begin
    dcache_h2d_o              = req_h2d_i[gnt_idx];
    dcache_h2d_o.req_valid    = arb_open & gnt_valid;
    dcache_h2d_o.notif_valid  = req_h2d_i[notif_sel].notif_valid;
    dcache_h2d_o.notif_reason = req_h2d_i[notif_sel].notif_reason;
  end

  // Completions reach only the owner, and only while a request is outstanding.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req_d2h_o[i]             = '0;
      req_d2h_o[i].req_ready   = arb_open & gnt_valid & (gnt_idx == 1'(i)) & dcache_d2h_i.req_ready;
      req_d2h_o[i].notif_ready = (notif_sel == 1'(i)) & dcache_d2h_i.notif_ready;
      if (state_q == WAIT && owner_q == 1'(i)) begin
        req_d2h_o[i].resp_valid   = dcache_d2h_i.resp_valid;
        req_d2h_o[i].resp_value   = dcache_d2h_i.resp_value;
        req_d2h_o[i].ex_valid     = dcache_d2h_i.ex_valid;
        req_d2h_o[i].ex_exception = dcache_d2h_i.ex_exception;
      end
    end
  end

  assign busy_o  = (state_q == WAIT);
  assign owner_o = owner_q;

`ifdef DCACHE_ARB_ASSERT_EN
  logic [3:0] err_q;
  logic [3:0] err_now;

  assign err_now = {
    dcache_h2d_o.req_valid & (state_q == WAIT) & ~completion,
    notif_lock_q & ~req_h2d_i[notif_owner_q].notif_valid,
    dcache_d2h_i.resp_valid & dcache_d2h_i.ex_valid,
    completion & (state_q == IDLE)
  };

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= '0;
    else       err_q <= err_q | err_now;
  end

  a_spurious_completion: assert property (@(posedge clk_i) disable iff (rst_i) !err_now[0]);
  a_resp_and_ex:         assert property (@(posedge clk_i) disable iff (rst_i) !err_now[1]);
  a_notif_dropped:       assert property (@(posedge clk_i) disable iff (rst_i) !err_now[2]);
  a_req_while_wait:      assert property (@(posedge clk_i) disable iff (rst_i) !err_now[3]);
`endif

endmodule

// File: tb/tb_dcache_arbiter.sv
// Directed bench for dcache_arbiter: reset, routing, contention, stalls, notifications.
module tb_dcache_arbiter;
  import muntjac_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_arbiter_if host0 ();
  dcache_arbiter_if host1 ();
  dcache_arbiter_if cache ();

  dcache_d2h_t [1:0] req_d2h;
  dcache_h2d_t       cache_h2d;
  logic              owner, busy;

  assign host0.d2h = req_d2h[0];
  assign host1.d2h = req_d2h[1];
  assign cache.h2d = cache_h2d;

  dcache_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_h2d_i    ({host1.h2d, host0.h2d}),
    .req_d2h_o    (req_d2h),
    .dcache_h2d_o (cache_h2d),
    .dcache_d2h_i (cache.d2h),
    .owner_o      (owner),
    .busy_o       (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    host0.h2d = '0;
    host1.h2d = '0;
    cache.d2h = '0;
    do_reset();
    settle();

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_req_valid", 64'(cache_h2d.req_valid), 64'd0);

    // Single host: load from r0, response three cycles after acceptance
    host0.h2d.req_valid   = 1'b1;
    host0.h2d.req_op      = OP_LOAD;
    host0.h2d.req_address = 64'h8000_1000;
    host0.h2d.req_size    = 2'd2;
    cache.d2h.req_ready   = 1'b1;
    settle();
    check("s_req_valid", 64'(cache_h2d.req_valid), 64'd1);
    check("s_addr", cache_h2d.req_address, 64'h8000_1000);
    check("s_r0_ready", 64'(req_d2h[0].req_ready), 64'd1);
    check("s_r1_ready", 64'(req_d2h[1].req_ready), 64'd0);
    tick();
    host0.h2d.req_valid = 1'b0;
    settle();
    check("s_busy_c1", 64'(busy), 64'd1);
    check("s_owner", 64'(owner), 64'd0);
    check("s_wait_req_valid", 64'(cache_h2d.req_valid), 64'd0);
    tick();
    check("s_busy_c2", 64'(busy), 64'd1);
    tick();
    cache.d2h.resp_valid = 1'b1;
    cache.d2h.resp_value = 64'hDEAD_BEEF;
    settle();
    check("s_busy_c3", 64'(busy), 64'd1);
    check("s_r0_resp_valid", 64'(req_d2h[0].resp_valid), 64'd1);
    check("s_r0_resp_value", req_d2h[0].resp_value, 64'hDEAD_BEEF);
    check("s_r1_resp_valid", 64'(req_d2h[1].resp_valid), 64'd0);
    tick();
    cache.d2h.resp_valid = 1'b0;
    settle();
    check("s_busy_after", 64'(busy), 64'd0);

    // Contention after reset: r0 wins, r1 accepted in r0's completion cycle
    do_reset();
    host0.h2d.req_valid   = 1'b1;
    host0.h2d.req_address = 64'h100;
    host1.h2d.req_valid   = 1'b1;
    host1.h2d.req_op      = OP_LOAD;
    host1.h2d.req_address = 64'h200;
    settle();
    check("c_addr_first", cache_h2d.req_address, 64'h100);
    check("c_r0_ready", 64'(req_d2h[0].req_ready), 64'd1);
    check("c_r1_ready", 64'(req_d2h[1].req_ready), 64'd0);
    tick();
    host0.h2d.req_valid = 1'b0;
    settle();
    check("c_owner0", 64'(owner), 64'd0);
    check("c_wait_req_valid", 64'(cache_h2d.req_valid), 64'd0);
    check("c_wait_r1_ready", 64'(req_d2h[1].req_ready), 64'd0);
    tick();
    cache.d2h.resp_valid = 1'b1;
    cache.d2h.resp_value = 64'h11;
    settle();
    check("c_b2b_req_valid", 64'(cache_h2d.req_valid), 64'd1);
    check("c_b2b_addr", cache_h2d.req_address, 64'h200);
    check("c_b2b_r1_ready", 64'(req_d2h[1].req_ready), 64'd1);
    check("c_r0_resp", 64'(req_d2h[0].resp_valid), 64'd1);
    check("c_r1_no_resp", 64'(req_d2h[1].resp_valid), 64'd0);
    tick();
    cache.d2h.resp_valid = 1'b0;
    host1.h2d.req_valid  = 1'b0;
    settle();
    check("c_busy_b2b", 64'(busy), 64'd1);
    check("c_owner1", 64'(owner), 64'd1);

    // Exception routed to r1 only
    cache.d2h.ex_valid              = 1'b1;
    cache.d2h.ex_exception.cause    = EXC_LOAD_PAGE_FAULT;
    cache.d2h.ex_exception.tval     = 64'h200;
    settle();
    check("e_r1_ex_valid", 64'(req_d2h[1].ex_valid), 64'd1);
    check("e_r1_cause", 64'(req_d2h[1].ex_exception.cause), 64'd13);
    check("e_r1_tval", req_d2h[1].ex_exception.tval, 64'h200);
    check("e_r0_ex_valid", 64'(req_d2h[0].ex_valid), 64'd0);
    check("e_r0_cause", 64'(req_d2h[0].ex_exception.cause), 64'd0);
    tick();
    cache.d2h.ex_valid = 1'b0;
    settle();
    check("e_busy_after", 64'(busy), 64'd0);

    // Ready stall: r1 held for four cycles, accepted on the fifth
    cache.d2h.req_ready   = 1'b0;
    host1.h2d.req_valid   = 1'b1;
    host1.h2d.req_op      = OP_STORE;
    host1.h2d.req_address = 64'h300;
    host1.h2d.req_value   = 64'hCAFE;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("st_addr_%0d", i), cache_h2d.req_address, 64'h300);
      check($sformatf("st_value_%0d", i), cache_h2d.req_value, 64'hCAFE);
      check($sformatf("st_valid_%0d", i), 64'(cache_h2d.req_valid), 64'd1);
      check($sformatf("st_busy_%0d", i), 64'(busy), 64'd0);
      tick();
    end
    cache.d2h.req_ready = 1'b1;
    settle();
    check("st_r1_ready", 64'(req_d2h[1].req_ready), 64'd1);
    tick();
    host1.h2d.req_valid = 1'b0;
    settle();
    check("st_busy", 64'(busy), 64'd1);
    check("st_owner", 64'(owner), 64'd1);
    cache.d2h.resp_valid = 1'b1;
    tick();
    cache.d2h.resp_valid = 1'b0;

    // Notification lock: r1 holds the grant until notif_ready
    host1.h2d.notif_valid  = 1'b1;
    host1.h2d.notif_reason = 1'b1;
    host0.h2d.notif_reason = 1'b0;
    cache.d2h.notif_ready  = 1'b0;
    settle();
    check("n_valid", 64'(cache_h2d.notif_valid), 64'd1);
    check("n_reason_r1", 64'(cache_h2d.notif_reason), 64'd1);
    tick();
    tick();
    host0.h2d.notif_valid = 1'b1;
    settle();
    check("n_locked_reason", 64'(cache_h2d.notif_reason), 64'd1);
    tick();
    cache.d2h.notif_ready = 1'b1;
    settle();
    check("n_r1_ready", 64'(req_d2h[1].notif_ready), 64'd1);
    check("n_r0_not_ready", 64'(req_d2h[0].notif_ready), 64'd0);
    tick();
    host1.h2d.notif_valid = 1'b0;
    settle();
    check("n_r0_reason", 64'(cache_h2d.notif_reason), 64'd0);
    check("n_r0_ready", 64'(req_d2h[0].notif_ready), 64'd1);
    check("n_r1_ready_off", 64'(req_d2h[1].notif_ready), 64'd0);
    tick();
    host0.h2d.notif_valid = 1'b0;
    cache.d2h.notif_ready = 1'b0;

    // Reset during WAIT, then a late response
    host0.h2d.req_valid   = 1'b1;
    host0.h2d.req_op      = OP_LOAD;
    host0.h2d.req_address = 64'h400;
    tick();
    host0.h2d.req_valid = 1'b0;
    settle();
    check("r_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("r_busy_after_rst", 64'(busy), 64'd0);
    check("r_owner_after_rst", 64'(owner), 64'd0);
    cache.d2h.resp_valid = 1'b1;
    cache.d2h.resp_value = 64'h5555;
    settle();
    check("r_late_r0", 64'(req_d2h[0].resp_valid), 64'd0);
    check("r_late_r1", 64'(req_d2h[1].resp_valid), 64'd0);
    tick();
    cache.d2h.resp_valid = 1'b0;
    settle();
    check("r_busy_late", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_arbiter.md
# dcache_arbiter

Shares one Muntjac data-cache port between two hosts. Requester 0 is the pipeline's `dcache_h2d` port. Requester 1 is a secondary host, such as a debug or harness memory accessor. The block sits between those hosts and the data cache. It grants one request at a time, routes each response or exception to the host that issued the request, and arbitrates the cache-notification channel on its own.

## Interface
Parameters:
- `NumReq`, 2, number of requesters. The value is fixed at 2; any other value is a fatal elaboration error.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous active-high reset
- `req_h2d_i`  in  `dcache_h2d_t [1:0]`  host-to-cache request and notification structs, one per requester
- `req_d2h_o`  out  `dcache_d2h_t [1:0]`  cache-to-host struct returned to each requester
- `dcache_h2d_o`  out  `dcache_h2d_t`  request and notification to the data cache
- `dcache_d2h_i`  in  `dcache_d2h_t`  ready, response, exception and notification-ready from the cache
- `owner_o`  out  1  index of the requester whose request is outstanding; valid while `busy_o` is 1
- `busy_o`  out  1  one request is outstanding

## Operation
- The request FSM has two states.
  - `IDLE`: no request is outstanding.
  - `WAIT`: one request was accepted and awaits completion.
- Grant selection in `IDLE`:
  - The grant goes to the selected requester that has `req_valid` set.
  - Only the granted requester's fields drive `dcache_h2d_o.req_*`.
  - `dcache_h2d_o.req_valid` is 1 only for that requester.
  - `req_d2h_o[g].req_ready` equals `dcache_d2h_i.req_ready`. The other requester sees `req_ready` = 0.
- Acceptance:
  - A request is accepted when `req_valid` and `req_ready` are both 1 at the cache.
  - On acceptance: latch the owner, move to `WAIT`, and update the round-robin pointer to the requester that was not granted.
- Completion:
  - Every accepted request ends with exactly one cycle in which `dcache_d2h_i.resp_valid` or `dcache_d2h_i.ex_valid` is 1.
  - `resp_valid`, `resp_value`, `ex_valid` and `ex_exception` pass combinationally to the owner only. The non-owner always sees `resp_valid` = 0 and `ex_valid` = 0.
  - On the completion cycle the FSM returns to `IDLE`.
- Back-to-back:
  - In the completion cycle the FSM behaves as `IDLE` for grant purposes.
  - A new request may therefore be accepted in the same cycle, and the FSM stays in `WAIT` with the new owner.
- In `WAIT` with no completion, `dcache_h2d_o.req_valid` = 0 and both requesters see `req_ready` = 0.
- A completion seen in `IDLE` is spurious. It is dropped, and under `DCACHE_ARB_ASSERT_EN` it also triggers an assertion.
- Notification channel:
  - The notification channel has its own one-bit grant register `notif_owner_q` and a lock flag `notif_lock_q`.
  - When unlocked, requester 0 has priority. The granted requester's `notif_valid` and `notif_reason` drive the cache.
  - If `notif_valid` is set but `notif_ready` is 0, the lock is set and the grant is held until `notif_ready` is 1.
  - `notif_ready` is returned only to the notification grantee.
  - Notifications are independent of the request FSM and may proceed while it is in `WAIT`.
- Reset (`rst_i` = 1 at a clock edge):
  - FSM returns to `IDLE`; round-robin pointer = 0; `notif_lock_q` = 0; `owner_q` = 0.
  - Outputs after reset: `busy_o` = 0, `owner_o` = 0, `dcache_h2d_o.req_valid` = 0 unless a requester is valid.
  - A reset asserted during `WAIT` abandons the outstanding request. A late response after reset is treated as spurious.

## Timing
- Request path, host to cache: combinational.
- Ready path: combinational from `dcache_d2h_i.req_ready` to the granted host.
- Response path: zero added latency.
- Arbitration decision: depends only on registered state plus the current cycle's `req_valid` bits.
- Throughput: one request per cache round trip, with no idle cycle inserted between completion and the next grant.
- Simultaneous valid requests in `IDLE`: the pointer picks the winner. The loser keeps `req_valid` asserted and is granted after the winner completes.

## Configuration
- `DCACHE_ARB_ASSERT_EN` defined:
  - Concurrent assertions for: completion in `IDLE`; `resp_valid` and `ex_valid` both set in one cycle; a host dropping `notif_valid` while locked; `req_valid` on the cache while in `WAIT` without completion.
  - Adds 1 bit per check as registered sticky error flags, visible in simulation only.
- Not defined: no assertions and no error flags. Functional behaviour is identical.

## Structure
- `muntjac_pkg`: holds `dcache_h2d_t`, `dcache_d2h_t`, and a new `dcache_arb_state_e` enum with values `IDLE` and `WAIT`.
- Sub-module `dcache_arb_rr`:
  - 2-way round-robin picker.
  - Inputs: `valid[1:0]` and `ptr`.
  - Outputs: `gnt_idx` and `gnt_valid`.
  - Combinational; the pointer register stays in the parent.

## Test plan
- Single host: requester 0 issues a load to `0x80001000` with `req_ready` = 1 and cache response `0xDEADBEEF` three cycles later. Requester 0 receives `resp_valid` with `0xDEADBEEF`. Requester 1 sees no `resp_valid`. `busy_o` is 1 for exactly 3 cycles.
- Contention: both hosts are valid in the same cycle after reset. Requester 0 is granted first. Requester 1 is accepted in requester 0's completion cycle, back-to-back with no gap.
- Exception routing: requester 1 owns a request and the cache asserts `ex_valid` with a load page fault. Only requester 1 sees `ex_valid` and the exception cause.
- Ready stall: `req_ready` is held at 0 for 4 cycles while requester 1 is valid. The grant stays on requester 1, the request fields stay stable at the cache output, and acceptance happens on cycle 5.
- Notification lock: requester 1 asserts `notif_valid`, `notif_ready` stays 0 for 2 cycles, then requester 0 asserts `notif_valid`. Requester 1 keeps the grant until `notif_ready` is 1, and requester 0 is served the next cycle.
- Reset during `WAIT`: `rst_i` is pulsed while `busy_o` is 1, then a late `resp_valid` arrives. No host receives `resp_valid`, `busy_o` = 0, and the assertion fires when `DCACHE_ARB_ASSERT_EN` is defined.
